// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine-side responder for the multi_dataflow control FSM: launches the HLS
// kernel through the ap_ctrl handshake, counts outStream0 beats and reports done.
module multi_dataflow_engine_ctrl #(
  parameter  int unsigned CNT_LEN = 1024,
  localparam int unsigned CW      = $clog2(CNT_LEN) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic          start_i,
  input  logic [CW-1:0] cnt_limit_i,
  input  logic          out_valid_i,
  input  logic          out_ready_i,
  input  logic          kernel_done_i,
  input  logic          kernel_idle_i,
  input  logic          kernel_ready_i,
  output logic          kernel_start_o,
  output logic [CW-1:0] cnt_o,
  output logic          done_o,
  output logic          ready_o,
  output logic          overrun_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] limit_q, limit_d;
  logic          done_seen_q, done_seen_d;
  logic          kstart_q, kstart_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          beat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      limit_q     <= '0;
      done_seen_q <= 1'b0;
      kstart_q    <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      done_seen_q <= done_seen_d;
      kstart_q    <= kstart_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    done_seen_d = done_seen_q;
    kstart_d    = kstart_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    beat        = out_valid_i & out_ready_i;

    if (clear_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      limit_d     = '0;
      done_seen_d = 1'b0;
      kstart_d    = 1'b0;
      done_d      = 1'b0;
      overrun_d   = 1'b0;
    end else if (enable_i) begin
      case (state_q)
        IDLE: begin
          if (start_i && kernel_idle_i) begin
            limit_d     = cnt_limit_i;
            cnt_d       = '0;
            overrun_d   = 1'b0;
            done_seen_d = 1'b0;
            // A zero-length job never touches the kernel.
            if (cnt_limit_i == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d  = LAUNCH;
              kstart_d = 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (kernel_ready_i) begin
            kstart_d = 1'b0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if ((cnt_q == limit_q) && (done_seen_q || kernel_done_i)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE: begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Beats and kernel done are tracked from launch on; the kernel may stream early.
      if (state_q == LAUNCH || state_q == RUN) begin
        if (kernel_done_i) done_seen_d = 1'b1;
        if (beat) begin
          if (cnt_q < limit_q) cnt_d = cnt_q + 1'b1;
          else                 overrun_d = 1'b1;
        end
      end
    end
  end

  assign kernel_start_o = kstart_q;
  assign cnt_o          = cnt_q;
  assign done_o         = done_q;
  assign overrun_o      = overrun_q;
  assign ready_o        = (state_q == IDLE) & kernel_idle_i;

endmodule
